terrain_store: RTL and testbench



---
 rtl/terrain_store.sv | 192 +++++++++++++++++++
 tb/tb_terrain_store.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/terrain_store.sv
// -----------------------------------------------------------------------------
// terrain_store
//   Column-organised terrain memory. Each word is one screen column; bit r is
//   pixel row r and a 1 means ground. After reset the store paints the initial
//   landscape one column per clock (INIT), then serves reads and accepts
//   blast write-backs (RUN).
//
// Ports
//   clk           in   1    system clock
//   reset         in   1    synchronous, active-high
//   rd_col        in   10   column read address (usually DrawX)
//   terrain_data  out  ROWS stored column for rd_col, one clock after sampling
//   surface_row   out  10   lowest set bit of terrain_data, one clock later;
//                           ROWS when the column is empty
//   wr_en         in   1    write strobe
//   wr_col        in   10   column write address
//   terrain_in    in   ROWS write data (deformed column)
//   ready         out  1    high once the initial landscape is complete
//   dbg_state     out  1    current FSM state (0 = INIT, 1 = RUN)
//
// Handshake: there is none. A write is accepted on every edge where wr_en is
// high in RUN with wr_col < COLS; a read address is accepted on every edge.
// Nothing ever stalls, so neither side carries a ready/valid pair.
// -----------------------------------------------------------------------------
module terrain_store #(
  parameter int COLS        = 640,
  parameter int ROWS        = 512,
  parameter int GROUND_BASE = 400
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [9:0]      rd_col,
  output logic [ROWS-1:0] terrain_data,
  output logic [9:0]      surface_row,
  input  logic            wr_en,
  input  logic [9:0]      wr_col,
  input  logic [ROWS-1:0] terrain_in,
  output logic            ready,
  output logic            dbg_state
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [9:0] COLS_W  = 10'(COLS);
  localparam logic [9:0] LAST_W  = 10'(COLS - 1);
  localparam logic [9:0] EMPTY_W = 10'(ROWS);
  localparam logic [9:0] BASE_W  = 10'(GROUND_BASE);

  state_e           state_q, state_d;
  logic [9:0]       init_cnt_q, init_cnt_d;
  logic             ready_q;
  logic [ROWS-1:0]  data_q, data_d;
  logic [9:0]       row_q, row_d;

  logic [ROWS-1:0]  mem_q [COLS];

  // ---------------------------------------------------------------------------
  // Initial profile: a triangle wave of period 128 columns, dipping 63 rows
  // above GROUND_BASE at the middle of each period.
  // ---------------------------------------------------------------------------
  logic [6:0]       prof_m;
  logic [6:0]       prof_dist;
  logic [9:0]       prof_h;
  logic [ROWS-1:0]  prof_word;

  always_comb begin
    prof_m    = init_cnt_q[6:0];
    // 127 - m equals the bitwise complement of m in 7 bits.
    prof_dist = prof_m[6] ? ~prof_m : prof_m;
    prof_h    = BASE_W - {3'b000, prof_dist};
    prof_word = '0;
    for (int r = 0; r < ROWS; r++) begin
      prof_word[r] = (10'(r) >= prof_h);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 10'd1;
        if (init_cnt_q == LAST_W) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory write port: INIT owns it; in RUN it takes in-range user writes.
  // ---------------------------------------------------------------------------
  logic             run_wr;
  logic             mem_we;
  logic [9:0]       mem_waddr;
  logic [ROWS-1:0]  mem_wdata;

  always_comb begin
    run_wr    = (state_q == ST_RUN) && wr_en && (wr_col < COLS_W);
    mem_we    = 1'b0;
    mem_waddr = wr_col;
    mem_wdata = terrain_in;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt_q;
      mem_wdata = prof_word;
    end else if (run_wr) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array: INIT rewrites every column after reset anyway.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage 1: registered column word with write-first bypass.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d = '0;
    if (state_q == ST_RUN) begin
      if (run_wr && (wr_col == rd_col)) begin
        data_d = terrain_in;
      end else if (rd_col < COLS_W) begin
        data_d = mem_q[rd_col];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage 2: lowest set row of the stage-1 word. Scanning downward makes
  // the last hit (the lowest index) win.
  // ---------------------------------------------------------------------------
  logic [9:0] pe_row;

  always_comb begin
    pe_row = EMPTY_W;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (data_q[r]) begin
        pe_row = 10'(r);
      end
    end
  end

  always_comb begin
    row_d = (state_q == ST_INIT) ? EMPTY_W : pe_row;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      row_q  <= EMPTY_W;
    end else begin
      data_q <= data_d;
      row_q  <= row_d;
    end
  end

  assign terrain_data = data_q;
  assign surface_row  = row_q;
  assign ready        = ready_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_terrain_store.sv
module tb_terrain_store;

  localparam int COLS = 640;
  localparam int ROWS = 512;
  localparam int GB   = 400;

  logic            clk;
  logic            reset;
  logic [9:0]      rd_col;
  logic [ROWS-1:0] terrain_data;
  logic [9:0]      surface_row;
  logic            wr_en;
  logic [9:0]      wr_col;
  logic [ROWS-1:0] terrain_in;
  logic            ready;
  logic            dbg_state;

  terrain_store dut (
    .clk          (clk),
    .reset        (reset),
    .rd_col       (rd_col),
    .terrain_data (terrain_data),
    .surface_row  (surface_row),
    .wr_en        (wr_en),
    .wr_col       (wr_col),
    .terrain_in   (terrain_in),
    .ready        (ready),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  logic [ROWS-1:0] model_mem [COLS];
  logic [ROWS-1:0] exp_data_q[$];
  logic [9:0]      exp_row_q[$];
  int              rd_list[$];
  int              er_list[$];
  int              n_vec = 0;
  int              n_err = 0;

  function automatic logic [ROWS-1:0] model_profile(int c);
    int m, h;
    logic [ROWS-1:0] w;
    m = c % 128;
    h = GB - ((m < 64) ? m : (127 - m));
    w = '0;
    for (int r = h; r < ROWS; r++) w[r] = 1'b1;
    return w;
  endfunction

  function automatic logic [9:0] model_row(logic [ROWS-1:0] w);
    for (int r = 0; r < ROWS; r++) begin
      if (w[r]) return 10'(r);
    end
    return 10'(ROWS);
  endfunction

  function automatic logic [ROWS-1:0] model_read(int c);
    return (c < COLS) ? model_mem[c] : '0;
  endfunction

  task automatic model_init();
    for (int c = 0; c < COLS; c++) model_mem[c] = model_profile(c);
  endtask

  task automatic check(string tag, logic [ROWS-1:0] obs, logic [ROWS-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pipelined reads from rd_list; expected rows come from er_list.
  task automatic read_seq(string tag);
    int n;
    n = rd_list.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        rd_col = 10'(rd_list[k]);
        exp_data_q.push_back(model_read(rd_list[k]));
        exp_row_q.push_back(10'(er_list[k]));
      end
      tick();
      if (k < n)
        check($sformatf("%s_data_c%0d", tag, rd_list[k]), terrain_data, exp_data_q.pop_front());
      if (k > 0)
        check($sformatf("%s_row_c%0d", tag, rd_list[k-1]), ROWS'(surface_row), ROWS'(exp_row_q.pop_front()));
    end
    rd_list.delete();
    er_list.delete();
  endtask

  task automatic add_read(int c, int row);
    rd_list.push_back(c);
    er_list.push_back(row);
  endtask

  task automatic write_col(int c, logic [ROWS-1:0] w);
    wr_en      = 1'b1;
    wr_col     = 10'(c);
    terrain_in = w;
    tick();
    wr_en      = 1'b0;
    if (c < COLS) model_mem[c] = w;
  endtask

  // Runs the INIT phase after reset drops, checking ready on every edge.
  task automatic run_init(bit drop_write);
    for (int i = 1; i <= COLS; i++) begin
      if (drop_write && i == 10) begin
        wr_en = 1'b1; wr_col = 10'd600; terrain_in = '0;
      end
      if (i == 5) rd_col = 10'd3;
      tick();
      wr_en = 1'b0;
      check($sformatf("ready_e%0d", i), ROWS'(ready), ROWS'(i == COLS));
      if (i == 5) check("init_data_held", terrain_data, '0);
      if (i == 6) check("init_row_held", ROWS'(surface_row), ROWS'(ROWS));
    end
    model_init();
  endtask

  logic [ROWS-1:0] blast;

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; rd_col = '0; wr_en = 1'b0; wr_col = '0; terrain_in = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", ROWS'(ready), '0);
    check("rst_data", terrain_data, '0);
    check("rst_row", ROWS'(surface_row), ROWS'(ROWS));
    check("rst_state", ROWS'(dbg_state), '0);

    // Power-up INIT with a write that must be dropped at clock 10.
    run_init(1'b1);
    check("run_state", ROWS'(dbg_state), ROWS'(1));

    // Spec spot points of the initial profile.
    add_read(0, 400); add_read(63, 337); add_read(64, 337);
    add_read(127, 400); add_read(191, 337); add_read(600, 361);
    add_read(639, 400); add_read(5, 395);
    read_seq("prof");

    // Full sweep against the model.
    for (int c = 0; c < COLS; c++) add_read(c, model_row(model_mem[c]));
    read_seq("sweep");

    // Blast write-back: ground removed from the top down through row 420.
    blast = '1;
    for (int r = 0; r <= 420; r++) blast[r] = 1'b0;
    write_col(100, blast);
    add_read(100, 421);
    read_seq("blast");

    // Same-cycle read/write bypass.
    wr_en = 1'b1; wr_col = 10'd5; rd_col = 10'd5; terrain_in = '0;
    model_mem[5] = '0;
    exp_data_q.push_back('0);
    exp_row_q.push_back(10'd512);
    tick();
    wr_en = 1'b0;
    check("byp_data", terrain_data, exp_data_q.pop_front());
    tick();
    check("byp_row", ROWS'(surface_row), ROWS'(exp_row_q.pop_front()));
    add_read(5, 512);
    read_seq("byp_after");

    // Random-content writes, read back.
    for (int k = 0; k < 4; k++) begin
      logic [ROWS-1:0] w;
      int c;
      for (int j = 0; j < ROWS / 32; j++) w[j*32 +: 32] = $urandom;
      c = $urandom_range(200, 599);
      write_col(c, w);
      add_read(c, model_row(w));
      read_seq("rand");
    end

    // Range guard.
    add_read(700, 512);
    read_seq("oor");
    write_col(650, '1);
    add_read(0, 400); add_read(639, 400);
    read_seq("oor_wr");

    // Mid-operation reset restores the profile.
    write_col(100, '1);
    write_col(200, '0);
    write_col(300, blast);
    reset = 1'b1;
    tick();
    check("mid_rst_ready", ROWS'(ready), '0);
    check("mid_rst_state", ROWS'(dbg_state), '0);
    reset = 1'b0;
    run_init(1'b0);
    add_read(100, 373); add_read(200, 345); add_read(300, 356); add_read(5, 395);
    read_seq("reinit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
